// File: rtl/value_delay_chain.sv
// value_delay_chain: five-tap single-bit delay line with registered
// edge-detect pulses on the first tap and a registered count of ones
// across the tap window. Everything updates on the rising edge of CLK;
// reset is synchronous and active-low.
module value_delay_chain #(
    parameter int   STAGES    = 5,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       value,
    output logic       value1,
    output logic       value2,
    output logic       value3,
    output logic       value4,
    output logic       value5,
    output logic       rise,
    output logic       fall,
    output logic [2:0] ones
);

    // taps[k] holds the input delayed by k clocks
    logic [STAGES:1] taps;
    logic [STAGES:1] taps_next;
    logic [2:0]      ones_next;

    // Next-state of the chain: every stage takes its predecessor's
    // pre-edge value, so a sample needs STAGES edges to reach the end.
    always_comb begin
        taps_next = {taps[STAGES-1:1], value};
    end

    // Population count of the post-edge taps, so ones tracks the taps
    // in the same cycle rather than lagging by one.
    always_comb begin
        ones_next = 3'd0;
        for (int i = 1; i <= STAGES; i++) begin
            ones_next = ones_next + 3'(taps_next[i]);
        end
    end

    // Chain, edge pulses and count; reset has priority over shifting.
    // The pulses compare taps 1 and 2 before the edge, which lines them
    // up with the transition arriving at tap 2.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            taps <= {STAGES{RESET_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
            ones <= 3'd0;
        end else begin
            taps <= taps_next;
            rise <= taps[1] & ~taps[2];
            fall <= ~taps[1] & taps[2];
            ones <= ones_next;
        end
    end

    assign value1 = taps[1];
    assign value2 = taps[2];
    assign value3 = taps[3];
    assign value4 = taps[4];
    assign value5 = taps[5];

endmodule

// File: tb/tb_value_delay_chain.sv
// Bench for value_delay_chain: a history-queue model of sampled inputs
// checked every cycle on the falling edge, plus hand-computed literal
// expectations at chosen points of each directed scenario.
module tb_value_delay_chain;

    logic       CLK;
    logic       RST_N;
    logic       value;
    logic       value1, value2, value3, value4, value5;
    logic       rise, fall;
    logic [2:0] ones;

    int tests_run = 0;
    int tests_failed = 0;

    value_delay_chain dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .value  (value),
        .value1 (value1),
        .value2 (value2),
        .value3 (value3),
        .value4 (value4),
        .value5 (value5),
        .rise   (rise),
        .fall   (fall),
        .ones   (ones)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: most recent sample at the front; reset empties the history,
    // and missing history reads as the reset value 0.
    logic hist[$];
    bit   model_valid = 1'b0;

    function automatic logic tap(int k);
        if (hist.size() >= k) return hist[k-1];
        return 1'b0;
    endfunction

    function automatic int model_ones();
        int s = 0;
        for (int k = 1; k <= 5; k++) s += int'(tap(k));
        return s;
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            hist.delete();
            model_valid = 1'b1;
        end else begin
            hist.push_front(value);
            if (hist.size() > 5) void'(hist.pop_back());
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (model_valid) begin
            check("m_value1", int'(value1), int'(tap(1)));
            check("m_value2", int'(value2), int'(tap(2)));
            check("m_value3", int'(value3), int'(tap(3)));
            check("m_value4", int'(value4), int'(tap(4)));
            check("m_value5", int'(value5), int'(tap(5)));
            // a transition arrives at tap 2 while tap 3 still holds the old level
            check("m_rise", int'(rise), int'(tap(2) & ~tap(3)));
            check("m_fall", int'(fall), int'(~tap(2) & tap(3)));
            check("m_ones", int'(ones), model_ones());
            if (rise === 1'b1 && fall === 1'b1) check("m_rise_fall_excl", 1, 0);
        end
    end

    int rise_cnt, fall_cnt;

    // One edge with the given inputs; returns 3 ns after the edge.
    task automatic tick(input logic v, input logic r);
        value = v;
        RST_N = r;
        @(posedge CLK);
        #3;
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
    endtask

    task automatic check_taps(input string name, input logic [4:0] exp15, input int exp_ones);
        check({name, "_taps"}, int'({value1, value2, value3, value4, value5}), int'(exp15));
        check({name, "_ones"}, int'(ones), exp_ones);
    endtask

    initial begin
        value = 1'b1;
        RST_N = 1'b0;

        // Reset with value=1 held for two edges
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_taps("reset", 5'b00000, 0);
        check("reset_rise", int'(rise), 0);
        check("reset_fall", int'(fall), 0);

        // Step response
        rise_cnt = 0; fall_cnt = 0;
        tick(1'b1, 1'b1); check_taps("step_e1", 5'b10000, 1);
        tick(1'b1, 1'b1); check_taps("step_e2", 5'b11000, 2);
        check("step_rise_e2", int'(rise), 1);
        tick(1'b1, 1'b1); check_taps("step_e3", 5'b11100, 3);
        check("step_rise_e3", int'(rise), 0);
        tick(1'b1, 1'b1); check_taps("step_e4", 5'b11110, 4);
        tick(1'b1, 1'b1); check_taps("step_e5", 5'b11111, 5);
        tick(1'b1, 1'b1); check_taps("step_e6", 5'b11111, 5);
        tick(1'b1, 1'b1);
        check("step_rise_count", rise_cnt, 1);
        check("step_fall_count", fall_cnt, 0);

        // Lone pulse walking through the chain
        tick(1'b0, 1'b0);
        rise_cnt = 0; fall_cnt = 0;
        tick(1'b1, 1'b1); check_taps("pulse_e1", 5'b10000, 1);
        tick(1'b0, 1'b1); check_taps("pulse_e2", 5'b01000, 1);
        check("pulse_rise_e2", int'(rise), 1);
        tick(1'b0, 1'b1); check_taps("pulse_e3", 5'b00100, 1);
        check("pulse_fall_e3", int'(fall), 1);
        tick(1'b0, 1'b1); check_taps("pulse_e4", 5'b00010, 1);
        tick(1'b0, 1'b1); check_taps("pulse_e5", 5'b00001, 1);
        tick(1'b0, 1'b1); check_taps("pulse_e6", 5'b00000, 0);
        check("pulse_rise_count", rise_cnt, 1);
        check("pulse_fall_count", fall_cnt, 1);

        // Alternating pattern
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
        check_taps("alt_e5", 5'b10101, 3);
        tick(1'b0, 1'b1); check_taps("alt_e6", 5'b01010, 2);
        tick(1'b1, 1'b1); check_taps("alt_e7", 5'b10101, 3);
        rise_cnt = 0; fall_cnt = 0;
        for (int i = 0; i < 4; i++) tick(((i % 2) == 0) ? 1'b0 : 1'b1, 1'b1);
        check("alt_rise_count", rise_cnt, 2);
        check("alt_fall_count", fall_cnt, 2);

        // Mid-stream reset discards everything in flight
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        check_taps("mid_loaded", 5'b11111, 5);
        tick(1'b1, 1'b0);
        check_taps("mid_reset", 5'b00000, 0);
        rise_cnt = 0; fall_cnt = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        check_taps("mid_after", 5'b00000, 0);
        check("mid_rise_count", rise_cnt, 0);
        check("mid_fall_count", fall_cnt, 0);

        // Reset glitch between edges must be ignored
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check_taps("glitch_before", 5'b01100, 2);
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        #1;
        check_taps("glitch_after", 5'b01100, 2);
        check("glitch_rise", int'(rise), 0);
        tick(1'b1, 1'b1);
        check_taps("glitch_next", 5'b10110, 3);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
